// File: rtl/hll_job_ctrl.sv
// HyperLogLog job controller: meters a software-sized job of 512-bit beats from
// the TCP RX stream into the HLL IP, generates TLAST itself, then waits for the
// IP's result write to reach DMA before reporting completion.
module hll_job_ctrl #(
    parameter int unsigned DATA_WIDTH = 512,
    parameter int unsigned TIMEOUT    = 65536
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    start,
    input  logic [31:0]             cfg_len,
    input  logic [63:0]             cfg_base_addr,
    input  logic                    s_axis_rx_valid,
    output logic                    s_axis_rx_ready,
    input  logic [DATA_WIDTH-1:0]   s_axis_rx_data,
    input  logic [DATA_WIDTH/8-1:0] s_axis_rx_keep,
    input  logic                    s_axis_rx_last,
    output logic                    m_axis_hll_valid,
    input  logic                    m_axis_hll_ready,
    output logic [DATA_WIDTH-1:0]   m_axis_hll_data,
    output logic [DATA_WIDTH/8-1:0] m_axis_hll_keep,
    output logic                    m_axis_hll_last,
    output logic [63:0]             hll_base_addr,
    input  logic                    s_hll_cmd_valid,
    output logic                    s_hll_cmd_ready,
    input  logic [95:0]             s_hll_cmd_data,
    input  logic                    s_hll_wr_valid,
    output logic                    s_hll_wr_ready,
    input  logic [31:0]             s_hll_wr_data,
    input  logic [3:0]              s_hll_wr_keep,
    input  logic                    s_hll_wr_last,
    output logic                    m_dma_cmd_valid,
    input  logic                    m_dma_cmd_ready,
    output logic [95:0]             m_dma_cmd_data,
    output logic                    m_dma_wr_valid,
    input  logic                    m_dma_wr_ready,
    output logic [31:0]             m_dma_wr_data,
    output logic [3:0]              m_dma_wr_keep,
    output logic                    m_dma_wr_last,
    output logic                    busy,
    output logic                    done,
    output logic [31:0]             beat_cnt,
    output logic [31:0]             cycle_cnt,
    output logic [2:0]              err
);

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e      state_q, state_d;
    logic [31:0] total_q;
    logic [31:0] beat_cnt_q;
    logic [31:0] cycle_cnt_q;
    logic [31:0] to_cnt_q;
    logic [63:0] base_q;
    logic [2:0]  err_q;

    logic len_ok, start_ok, start_bad, rx_hs, final_beat, wr_last_hs, to_hit;

    assign len_ok     = (cfg_len != 32'd0) && (cfg_len[5:0] == 6'd0);
    assign start_ok   = start && (state_q == StIdle) && len_ok;
    assign start_bad  = start && (state_q == StIdle) && !len_ok;
    assign rx_hs      = (state_q == StRun) && s_axis_rx_valid && m_axis_hll_ready;
    assign final_beat = (beat_cnt_q == total_q - 32'd1);
    assign wr_last_hs = s_hll_wr_valid && m_dma_wr_ready && s_hll_wr_last;
    assign to_hit     = (to_cnt_q == TIMEOUT - 32'd1);

    // Write path is a pure pass-through in every state so late results still drain.
    assign m_dma_cmd_valid = s_hll_cmd_valid;
    assign s_hll_cmd_ready = m_dma_cmd_ready;
    assign m_dma_cmd_data  = s_hll_cmd_data;
    assign m_dma_wr_valid  = s_hll_wr_valid;
    assign s_hll_wr_ready  = m_dma_wr_ready;
    assign m_dma_wr_data   = s_hll_wr_data;
    assign m_dma_wr_keep   = s_hll_wr_keep;
    assign m_dma_wr_last   = s_hll_wr_last;

    assign m_axis_hll_data = s_axis_rx_data;
    assign m_axis_hll_keep = s_axis_rx_keep;
    assign hll_base_addr   = base_q;
    assign beat_cnt        = beat_cnt_q;
    assign cycle_cnt       = cycle_cnt_q;
    assign err             = err_q;

    // State register.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (start_ok) state_d = StRun;
            StRun:   if (rx_hs && final_beat) state_d = StDrain;
            StDrain: if (wr_last_hs || to_hit) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM-driven outputs; the RX stream is only open while running.
    always_comb begin
        busy             = (state_q != StIdle);
        done             = (state_q == StDone);
        s_axis_rx_ready  = 1'b0;
        m_axis_hll_valid = 1'b0;
        m_axis_hll_last  = 1'b0;
        if (state_q == StRun) begin
            s_axis_rx_ready  = m_axis_hll_ready;
            m_axis_hll_valid = s_axis_rx_valid;
            m_axis_hll_last  = final_beat;
        end
    end

    // Job registers, counters and sticky error flags.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            total_q     <= '0;
            base_q      <= '0;
            beat_cnt_q  <= '0;
            cycle_cnt_q <= '0;
            to_cnt_q    <= '0;
            err_q       <= '0;
        end else begin
            if (state_q != StIdle) cycle_cnt_q <= cycle_cnt_q + 32'd1;
            case (state_q)
                StIdle: begin
                    if (start_ok) begin
                        total_q     <= cfg_len >> 6;
                        base_q      <= cfg_base_addr;
                        beat_cnt_q  <= '0;
                        cycle_cnt_q <= '0;
                        err_q       <= '0;
                    end else if (start_bad) begin
                        err_q[0] <= 1'b1;
                    end
                end
                StRun: begin
                    if (rx_hs) beat_cnt_q <= beat_cnt_q + 32'd1;
                    // Upstream last is only an error when it disagrees with our count.
                    if (rx_hs && s_axis_rx_last && !final_beat) err_q[1] <= 1'b1;
                    if (rx_hs && final_beat) to_cnt_q <= '0;
                end
                StDrain: begin
                    to_cnt_q <= to_cnt_q + 32'd1;
                    // A last arriving on the limit cycle wins over the timeout.
                    if (to_hit && !wr_last_hs) err_q[2] <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hll_job_ctrl.sv
// Self-checking bench for hll_job_ctrl: scoreboards the RX->HLL stream and the
// HLL->DMA write path, and checks job status per scenario.
module tb_hll_job_ctrl;

    localparam int DW = 512;
    localparam int KW = DW / 8;

    typedef struct {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
    } hll_exp_t;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } wr_exp_t;

    logic          clk = 1'b0;
    logic          rstn;
    logic          start;
    logic [31:0]   cfg_len;
    logic [63:0]   cfg_base_addr;
    logic          s_axis_rx_valid, s_axis_rx_ready, s_axis_rx_last;
    logic [DW-1:0] s_axis_rx_data;
    logic [KW-1:0] s_axis_rx_keep;
    logic          m_axis_hll_valid, m_axis_hll_ready, m_axis_hll_last;
    logic [DW-1:0] m_axis_hll_data;
    logic [KW-1:0] m_axis_hll_keep;
    logic [63:0]   hll_base_addr;
    logic          s_hll_cmd_valid, s_hll_cmd_ready;
    logic [95:0]   s_hll_cmd_data;
    logic          s_hll_wr_valid, s_hll_wr_ready, s_hll_wr_last;
    logic [31:0]   s_hll_wr_data;
    logic [3:0]    s_hll_wr_keep;
    logic          m_dma_cmd_valid, m_dma_cmd_ready;
    logic [95:0]   m_dma_cmd_data;
    logic          m_dma_wr_valid, m_dma_wr_ready, m_dma_wr_last;
    logic [31:0]   m_dma_wr_data;
    logic [3:0]    m_dma_wr_keep;
    logic          busy, done;
    logic [31:0]   beat_cnt, cycle_cnt;
    logic [2:0]    err;

    int checks = 0;
    int failures = 0;
    int busy_seen = 0;
    int done_seen = 0;

    hll_exp_t    hll_q[$];
    logic [95:0] cmd_q[$];
    wr_exp_t     wr_q[$];

    hll_job_ctrl #(.DATA_WIDTH(DW), .TIMEOUT(16)) dut (
        .clk(clk), .rstn(rstn), .start(start), .cfg_len(cfg_len), .cfg_base_addr(cfg_base_addr),
        .s_axis_rx_valid(s_axis_rx_valid), .s_axis_rx_ready(s_axis_rx_ready),
        .s_axis_rx_data(s_axis_rx_data), .s_axis_rx_keep(s_axis_rx_keep),
        .s_axis_rx_last(s_axis_rx_last),
        .m_axis_hll_valid(m_axis_hll_valid), .m_axis_hll_ready(m_axis_hll_ready),
        .m_axis_hll_data(m_axis_hll_data), .m_axis_hll_keep(m_axis_hll_keep),
        .m_axis_hll_last(m_axis_hll_last), .hll_base_addr(hll_base_addr),
        .s_hll_cmd_valid(s_hll_cmd_valid), .s_hll_cmd_ready(s_hll_cmd_ready),
        .s_hll_cmd_data(s_hll_cmd_data),
        .s_hll_wr_valid(s_hll_wr_valid), .s_hll_wr_ready(s_hll_wr_ready),
        .s_hll_wr_data(s_hll_wr_data), .s_hll_wr_keep(s_hll_wr_keep),
        .s_hll_wr_last(s_hll_wr_last),
        .m_dma_cmd_valid(m_dma_cmd_valid), .m_dma_cmd_ready(m_dma_cmd_ready),
        .m_dma_cmd_data(m_dma_cmd_data),
        .m_dma_wr_valid(m_dma_wr_valid), .m_dma_wr_ready(m_dma_wr_ready),
        .m_dma_wr_data(m_dma_wr_data), .m_dma_wr_keep(m_dma_wr_keep),
        .m_dma_wr_last(m_dma_wr_last),
        .busy(busy), .done(done), .beat_cnt(beat_cnt), .cycle_cnt(cycle_cnt), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] pat(input int i);
        logic [31:0] w;
        w = 32'(i) ^ 32'hA5A5_0000;
        return {16{w}};
    endfunction

    function automatic logic [KW-1:0] kpat(input int i);
        return {56'hFF_FFFF_FFFF_FFFF, 8'(i)};
    endfunction

    // Scoreboard monitor: pops expected items whenever the DUT completes a transfer.
    always @(negedge clk) begin
        hll_exp_t he;
        wr_exp_t  we;
        logic [95:0] ce;
        if (rstn) begin
            if (busy) busy_seen++;
            if (done) done_seen++;
            if (m_axis_hll_valid && m_axis_hll_ready) begin
                checks++;
                if (hll_q.size() == 0) begin
                    failures++;
                    $display("FAIL hll_unexpected_beat got data=%h last=%b want none",
                             m_axis_hll_data[31:0], m_axis_hll_last);
                end else begin
                    he = hll_q.pop_front();
                    if (m_axis_hll_data !== he.data || m_axis_hll_keep !== he.keep ||
                        m_axis_hll_last !== he.last) begin
                        failures++;
                        $display("FAIL hll_beat got data=%h keep=%h last=%b want data=%h keep=%h last=%b",
                                 m_axis_hll_data[31:0], m_axis_hll_keep[7:0], m_axis_hll_last,
                                 he.data[31:0], he.keep[7:0], he.last);
                    end
                end
            end
            if (m_dma_cmd_valid && m_dma_cmd_ready) begin
                checks++;
                ce = (cmd_q.size() != 0) ? cmd_q.pop_front() : 96'hx;
                if (m_dma_cmd_data !== ce) begin
                    failures++;
                    $display("FAIL dma_cmd got=%h want=%h", m_dma_cmd_data, ce);
                end
            end
            if (m_dma_wr_valid && m_dma_wr_ready) begin
                checks++;
                if (wr_q.size() == 0) begin
                    failures++;
                    $display("FAIL dma_wr_unexpected got=%h want none", m_dma_wr_data);
                end else begin
                    we = wr_q.pop_front();
                    if (m_dma_wr_data !== we.data || m_dma_wr_keep !== we.keep ||
                        m_dma_wr_last !== we.last) begin
                        failures++;
                        $display("FAIL dma_wr got=%h/%h/%b want=%h/%h/%b", m_dma_wr_data,
                                 m_dma_wr_keep, m_dma_wr_last, we.data, we.keep, we.last);
                    end
                end
            end
        end
    end

    task automatic do_start(input logic [31:0] len, input logic [63:0] base);
        busy_seen = 0;
        done_seen = 0;
        @(posedge clk); #1;
        start = 1'b1;
        cfg_len = len;
        cfg_base_addr = base;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Feeds RX beats; returns in the cycle after the last accepted beat.
    task automatic drive_stream(input int nbeats, input bit toggle, input int early,
                                input int stop_at);
        int idx = 0;
        int cyc = 0;
        int pushed = -1;
        hll_exp_t e;
        while (idx < nbeats && idx < stop_at && cyc < 2000) begin
            @(posedge clk); #1;
            if (pushed != idx) begin
                e.data = pat(idx);
                e.keep = kpat(idx);
                e.last = (idx == nbeats - 1);
                hll_q.push_back(e);
                pushed = idx;
            end
            s_axis_rx_valid = 1'b1;
            s_axis_rx_data = pat(idx);
            s_axis_rx_keep = kpat(idx);
            s_axis_rx_last = (idx == early);
            m_axis_hll_ready = toggle ? (cyc % 2 == 0) : 1'b1;
            @(negedge clk);
            if (s_axis_rx_ready) idx++;
            cyc++;
        end
        if (idx < nbeats && idx < stop_at) begin
            failures++;
            $display("FAIL stream_stalled got=%0d beats want=%0d", idx, nbeats);
        end
        @(posedge clk); #1;
        s_axis_rx_valid = 1'b0;
        s_axis_rx_last = 1'b0;
        m_axis_hll_ready = 1'b1;
    endtask

    // IP model: one command then nwords data words; DMA ready held low for `stall` cycles.
    // Returns in the cycle after the last-word handshake.
    task automatic ip_write(input int nwords, input int stall);
        int cyc = 0;
        int left = stall;
        bit hs = 0;
        wr_exp_t e;
        @(posedge clk); #1;
        s_hll_cmd_valid = 1'b1;
        s_hll_cmd_data = {32'hC0DE_0000, 32'(nwords), 32'h1234_5678};
        cmd_q.push_back(s_hll_cmd_data);
        do begin
            @(negedge clk);
            hs = s_hll_cmd_ready;
            @(posedge clk); #1;
            cyc++;
        end while (!hs && cyc < 50);
        s_hll_cmd_valid = 1'b0;
        for (int w = 0; w < nwords; w++) begin
            e.data = 32'hBEEF_0000 + 32'(w);
            e.keep = 4'(w + 1);
            e.last = (w == nwords - 1);
            wr_q.push_back(e);
            s_hll_wr_valid = 1'b1;
            s_hll_wr_data = e.data;
            s_hll_wr_keep = e.keep;
            s_hll_wr_last = e.last;
            hs = 0;
            while (!hs && cyc < 50) begin
                m_dma_wr_ready = (left > 0) ? 1'b0 : 1'b1;
                @(negedge clk);
                if (!m_dma_wr_ready) begin
                    checks++;
                    if (m_dma_wr_valid !== 1'b1 || m_dma_wr_data !== e.data) begin
                        failures++;
                        $display("FAIL dma_hold got=%b/%h want=1/%h", m_dma_wr_valid,
                                 m_dma_wr_data, e.data);
                    end
                end
                hs = s_hll_wr_ready;
                if (left > 0) left--;
                @(posedge clk); #1;
                cyc++;
            end
        end
        if (!hs) begin
            failures++;
            $display("FAIL ip_write_stalled got=0 want=1 handshake");
        end
        s_hll_wr_valid = 1'b0;
        s_hll_wr_last = 1'b0;
        m_dma_wr_ready = 1'b1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        s_axis_rx_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if ({busy, done, err, m_axis_hll_valid, s_axis_rx_ready, m_axis_hll_last} !== 8'd0) begin
            failures++;
            $display("FAIL reset_flags got=%b want=0", {busy, done, err, m_axis_hll_valid,
                     s_axis_rx_ready, m_axis_hll_last});
        end
        checks++;
        if (beat_cnt !== 0 || cycle_cnt !== 0 || hll_base_addr !== 0) begin
            failures++;
            $display("FAIL reset_regs got=%0h/%0h/%0h want=0/0/0", beat_cnt, cycle_cnt,
                     hll_base_addr);
        end
        @(posedge clk); #1;
        rstn = 1'b1;
        s_axis_rx_valid = 1'b0;
    endtask

    task automatic test_nominal();
        busy_seen = 0;
        done_seen = 0;
        @(posedge clk); #1;
        start = 1'b1;
        cfg_len = 32'd8192;
        cfg_base_addr = 64'h1000;
        s_axis_rx_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (s_axis_rx_ready !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL start_cycle_closed got=%b%b want=00", s_axis_rx_ready, busy);
        end
        @(posedge clk); #1;
        start = 1'b0;
        s_axis_rx_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || hll_base_addr !== 64'h1000) begin
            failures++;
            $display("FAIL nominal_started got=%b/%0h want=1/1000", busy, hll_base_addr);
        end
        drive_stream(128, 1'b0, -1, 128);
        ip_write(4, 0);
        @(negedge clk);
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL nominal_done_pulse got=%b want=1", done);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || done_seen != 1) begin
            failures++;
            $display("FAIL nominal_end got=%b%b/%0d want=00/1", done, busy, done_seen);
        end
        checks++;
        if (beat_cnt !== 32'd128 || err !== 3'b000 || cycle_cnt !== 32'(busy_seen)) begin
            failures++;
            $display("FAIL nominal_status got=%0d/%b/%0d want=128/000/%0d", beat_cnt, err,
                     cycle_cnt, busy_seen);
        end
        checks++;
        if (hll_q.size() != 0 || cmd_q.size() != 0 || wr_q.size() != 0) begin
            failures++;
            $display("FAIL nominal_drained got=%0d/%0d/%0d want=0/0/0", hll_q.size(),
                     cmd_q.size(), wr_q.size());
        end
    endtask

    task automatic test_backpressure();
        do_start(32'd8192, 64'h2000);
        drive_stream(128, 1'b1, -1, 128);
        ip_write(3, 5);
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || beat_cnt !== 32'd128 || err !== 3'b000) begin
            failures++;
            $display("FAIL bp_status got=%b/%0d/%b want=1/128/000", done, beat_cnt, err);
        end
        checks++;
        if (hll_q.size() != 0 || wr_q.size() != 0) begin
            failures++;
            $display("FAIL bp_drained got=%0d/%0d want=0/0", hll_q.size(), wr_q.size());
        end
        @(negedge clk);
    endtask

    task automatic test_bad_len();
        logic [31:0] lens [2];
        lens[0] = 32'd100;
        lens[1] = 32'd0;
        for (int i = 0; i < 2; i++) begin
            do_start(lens[i], 64'h3000);
            s_axis_rx_valid = 1'b1;
            @(negedge clk);
            checks++;
            if (err !== 3'b001 || busy !== 1'b0 || s_axis_rx_ready !== 1'b0) begin
                failures++;
                $display("FAIL bad_len_%0d got=%b/%b/%b want=001/0/0", lens[i], err, busy,
                         s_axis_rx_ready);
            end
            s_axis_rx_valid = 1'b0;
        end
    endtask

    task automatic test_early_last();
        do_start(32'd4096, 64'h4000);
        drive_stream(64, 1'b0, 10, 64);
        ip_write(1, 0);
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || beat_cnt !== 32'd64 || err !== 3'b010 || hll_q.size() != 0) begin
            failures++;
            $display("FAIL early_last got=%b/%0d/%b/%0d want=1/64/010/0", done, beat_cnt, err,
                     hll_q.size());
        end
        @(negedge clk);
    endtask

    task automatic test_single_beat();
        do_start(32'd64, 64'h5000);
        drive_stream(1, 1'b0, -1, 1);
        ip_write(1, 0);
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || beat_cnt !== 32'd1 || err !== 3'b000 || hll_q.size() != 0) begin
            failures++;
            $display("FAIL single_beat got=%b/%0d/%b/%0d want=1/1/000/0", done, beat_cnt, err,
                     hll_q.size());
        end
        @(negedge clk);
    endtask

    task automatic test_timeout();
        int k = 0;
        bit seen = 0;
        do_start(32'd640, 64'h6000);
        drive_stream(10, 1'b0, -1, 10);
        while (!seen && k < 100) begin
            @(negedge clk);
            if (done) seen = 1;
            else begin
                k++;
                @(posedge clk); #1;
            end
        end
        checks++;
        if (!seen || k != 16 || err !== 3'b100) begin
            failures++;
            $display("FAIL timeout got=%b/%0d/%b want=1/16/100", seen, k, err);
        end
        // A start presented during DONE must be ignored.
        start = 1'b1;
        cfg_len = 32'd640;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || err !== 3'b100) begin
            failures++;
            $display("FAIL start_in_done got=%b/%b want=0/100", busy, err);
        end
    endtask

    task automatic test_last_at_limit();
        wr_exp_t e;
        do_start(32'd640, 64'h7000);
        drive_stream(10, 1'b0, -1, 10);
        repeat (15) @(posedge clk);
        #1;
        e.data = 32'hFACE_0001;
        e.keep = 4'hF;
        e.last = 1'b1;
        wr_q.push_back(e);
        s_hll_wr_valid = 1'b1;
        s_hll_wr_data = e.data;
        s_hll_wr_keep = e.keep;
        s_hll_wr_last = 1'b1;
        @(posedge clk); #1;
        s_hll_wr_valid = 1'b0;
        s_hll_wr_last = 1'b0;
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || err !== 3'b000 || wr_q.size() != 0) begin
            failures++;
            $display("FAIL last_at_limit got=%b/%b/%0d want=1/000/0", done, err, wr_q.size());
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_job();
        do_start(32'd8192, 64'h8000);
        drive_stream(128, 1'b0, -1, 40);
        rstn = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
        s_axis_rx_valid = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, done, err, m_axis_hll_valid, m_axis_hll_last, s_axis_rx_ready} !== 8'd0 ||
            beat_cnt !== 0 || cycle_cnt !== 0 || hll_base_addr !== 0) begin
            failures++;
            $display("FAIL reset_mid_job got=%b/%0d/%0d/%0h want=0/0/0/0", {busy, done, err,
                     m_axis_hll_valid, m_axis_hll_last, s_axis_rx_ready}, beat_cnt, cycle_cnt,
                     hll_base_addr);
        end
        s_axis_rx_valid = 1'b0;
        hll_q.delete();
        do_start(32'd640, 64'h9000);
        drive_stream(10, 1'b0, -1, 10);
        ip_write(2, 0);
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || beat_cnt !== 32'd10 || err !== 3'b000 ||
            hll_base_addr !== 64'h9000) begin
            failures++;
            $display("FAIL after_reset_job got=%b/%0d/%b/%0h want=1/10/000/9000", done,
                     beat_cnt, err, hll_base_addr);
        end
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0;
        start = 1'b0;
        cfg_len = '0;
        cfg_base_addr = '0;
        s_axis_rx_valid = 1'b0;
        s_axis_rx_data = '0;
        s_axis_rx_keep = '0;
        s_axis_rx_last = 1'b0;
        m_axis_hll_ready = 1'b1;
        s_hll_cmd_valid = 1'b0;
        s_hll_cmd_data = '0;
        s_hll_wr_valid = 1'b0;
        s_hll_wr_data = '0;
        s_hll_wr_keep = '0;
        s_hll_wr_last = 1'b0;
        m_dma_cmd_ready = 1'b1;
        m_dma_wr_ready = 1'b1;

        test_reset();
        test_nominal();
        test_backpressure();
        test_bad_len();
        test_early_last();
        test_single_beat();
        test_timeout();
        test_last_at_limit();
        test_reset_mid_job();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
